// File: rtl/qam16_mapper.sv
// QAM16 mapper: packs 4 serial bits MSB-first into a symbol, maps {b3,b2}/{b1,b0}
// to Q1.11 I/Q levels and emits SPS samples per symbol (mapped value, then zeros).
module qam16_mapper #(
  parameter int DATA_WIDTH = 12,
  parameter int SPS        = 4,
  parameter bit GRAY_EN    = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         bit_in,
  input  logic                         bit_valid,
  output logic                         bit_ready,
  output logic signed [DATA_WIDTH-1:0] sample_i,
  output logic signed [DATA_WIDTH-1:0] sample_q,
  output logic                         sample_valid,
  input  logic                         sample_ready,
  output logic                         sym_start
);

  localparam int unsigned PW         = (SPS > 2) ? $clog2(SPS) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(SPS - 1);
  localparam logic [2:0]    FULL       = 3'd4;

  logic [2:0]                  count, count_nx;
  logic [3:0]                  shreg, shreg_nx;
  logic                        busy, busy_nx;
  logic [PW-1:0]               phase, phase_nx;
  logic signed [DATA_WIDTH-1:0] i_nx, q_nx;
  logic                        start_nx;
  logic                        bit_xfer, smp_xfer, last_xfer, load;

  // Two bits to amplitude; Gray input is first converted to its binary rank.
  function automatic logic signed [DATA_WIDTH-1:0] map_level(input logic [1:0] b);
    logic [1:0] rank;
    rank = GRAY_EN ? {b[1], b[1] ^ b[0]} : b;
    case (rank)
      2'd0:    map_level = DATA_WIDTH'(-1943);
      2'd1:    map_level = DATA_WIDTH'(-648);
      2'd2:    map_level = DATA_WIDTH'(648);
      default: map_level = DATA_WIDTH'(1943);
    endcase
  endfunction

  always_comb begin
    bit_ready    = !rst && (count < FULL);
    sample_valid = busy;
  end

  // Handshakes and symbol load decision; load may coincide with the last-phase transfer.
  always_comb begin
    bit_xfer  = bit_valid && bit_ready;
    smp_xfer  = busy && sample_ready;
    last_xfer = smp_xfer && (phase == LAST_PHASE);
    load      = (count == FULL) && (!busy || last_xfer);
  end

  always_comb begin
    count_nx = count;
    shreg_nx = shreg;
    busy_nx  = busy;
    phase_nx = phase;
    i_nx     = sample_i;
    q_nx     = sample_q;
    start_nx = sym_start;

    if (bit_xfer) begin
      count_nx = count + 3'd1;
      shreg_nx = {shreg[2:0], bit_in};
    end

    if (smp_xfer) begin
      i_nx     = '0;
      q_nx     = '0;
      start_nx = 1'b0;
      if (last_xfer) begin
        busy_nx  = 1'b0;
        phase_nx = '0;
      end else begin
        phase_nx = phase + PW'(1);
      end
    end

    // Loading overrides the wrap so back-to-back symbols stream without a bubble.
    if (load) begin
      count_nx = '0;
      busy_nx  = 1'b1;
      phase_nx = '0;
      i_nx     = map_level(shreg[3:2]);
      q_nx     = map_level(shreg[1:0]);
      start_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      shreg     <= '0;
      busy      <= 1'b0;
      phase     <= '0;
      sample_i  <= '0;
      sample_q  <= '0;
      sym_start <= 1'b0;
    end else begin
      count     <= count_nx;
      shreg     <= shreg_nx;
      busy      <= busy_nx;
      phase     <= phase_nx;
      sample_i  <= i_nx;
      sample_q  <= q_nx;
      sym_start <= start_nx;
    end
  end

endmodule

// File: tb/tb_qam16_mapper.sv
// Scoreboard bench for qam16_mapper: three configurations (Gray/SPS4, natural/SPS4,
// Gray/SPS7) share stimulus; each gets its own expected-sample queue.
module tb_qam16_mapper;

  typedef struct {
    logic signed [11:0] i;
    logic signed [11:0] q;
    logic               st;
  } exp_t;

  logic clk = 1'b0;
  logic rst, bit_in, bit_valid, sample_ready;
  logic br [3];
  logic sv [3];
  logic ss [3];
  logic signed [11:0] si [3];
  logic signed [11:0] sq [3];

  exp_t exp_q [3][$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qam16_mapper #(.DATA_WIDTH(12), .SPS(4), .GRAY_EN(1'b1)) dut_g4 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(br[0]),
    .sample_i(si[0]), .sample_q(sq[0]), .sample_valid(sv[0]), .sample_ready(sample_ready),
    .sym_start(ss[0]));

  qam16_mapper #(.DATA_WIDTH(12), .SPS(4), .GRAY_EN(1'b0)) dut_n4 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(br[1]),
    .sample_i(si[1]), .sample_q(sq[1]), .sample_valid(sv[1]), .sample_ready(sample_ready),
    .sym_start(ss[1]));

  qam16_mapper #(.DATA_WIDTH(12), .SPS(7), .GRAY_EN(1'b1)) dut_g7 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(br[2]),
    .sample_i(si[2]), .sample_q(sq[2]), .sample_valid(sv[2]), .sample_ready(sample_ready),
    .sym_start(ss[2]));

  function automatic int sps_of(input int k);
    return (k == 2) ? 7 : 4;
  endfunction

  // Hand-written level tables.
  function automatic int lvl(input logic [1:0] b, input bit gray);
    if (gray) begin
      case (b)
        2'b00:   return -1943;
        2'b01:   return -648;
        2'b11:   return 648;
        default: return 1943;
      endcase
    end else begin
      case (b)
        2'b00:   return -1943;
        2'b01:   return -648;
        2'b10:   return 648;
        default: return 1943;
      endcase
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [3:0]         msh  [3];
    int                 mcnt [3];
    bit                 hold [3];
    logic signed [11:0] hi   [3];
    logic signed [11:0] hq   [3];
    logic               hs   [3];
    exp_t               e;
    for (int k = 0; k < 3; k++) begin
      msh[k] = '0; mcnt[k] = 0; hold[k] = 1'b0; hi[k] = '0; hq[k] = '0; hs[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int k = 0; k < 3; k++) begin
          exp_q[k].delete();
          msh[k] = '0; mcnt[k] = 0; hold[k] = 1'b0;
        end
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (hold[k]) begin
            chk($sformatf("stall_valid%0d", k), int'(sv[k]), 1);
            chk($sformatf("stall_i%0d", k), int'(si[k]), int'(hi[k]));
            chk($sformatf("stall_q%0d", k), int'(sq[k]), int'(hq[k]));
            chk($sformatf("stall_start%0d", k), int'(ss[k]), int'(hs[k]));
          end
          if (sv[k] && sample_ready) begin
            if (exp_q[k].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_sample dut%0d actual=(%0d,%0d) expected=none",
                       k, si[k], sq[k]);
            end else begin
              e = exp_q[k].pop_front();
              chk($sformatf("sample_i%0d", k), int'(si[k]), int'(e.i));
              chk($sformatf("sample_q%0d", k), int'(sq[k]), int'(e.q));
              chk($sformatf("sym_start%0d", k), int'(ss[k]), int'(e.st));
            end
          end
          hold[k] = sv[k] && !sample_ready;
          hi[k] = si[k]; hq[k] = sq[k]; hs[k] = ss[k];
          if (bit_valid && br[k]) begin
            msh[k] = {msh[k][2:0], bit_in};
            mcnt[k]++;
            if (mcnt[k] == 4) begin
              mcnt[k] = 0;
              for (int p = 0; p < sps_of(k); p++) begin
                e.st = (p == 0);
                e.i  = (p == 0) ? 12'(lvl(msh[k][3:2], k != 1)) : 12'sd0;
                e.q  = (p == 0) ? 12'(lvl(msh[k][1:0], k != 1)) : 12'sd0;
                exp_q[k].push_back(e);
              end
            end
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int n;
    n = 0;
    bit_valid = 1'b1;
    bit_in    = b;
    while (!br[0] && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("send_bit_timeout", n, 0);
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic send_nibble(input logic [3:0] s);
    for (int i = 3; i >= 0; i--) send_bit(s[i]);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    sample_ready = 1'b1;
    bit_valid    = 1'b0;
    while (n < 1000 && (sv[0] || sv[1] || sv[2] ||
           exp_q[0].size() != 0 || exp_q[1].size() != 0 || exp_q[2].size() != 0)) begin
      tick();
      n++;
    end
    chk("drain_pending", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("ready_after_rst", int'(br[0]), 1);
  endtask

  initial begin
    int acc0, acc2, cyc, n;
    logic [3:0] pat;
    fork
      monitor();
    join_none

    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; sample_ready = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_valid%0d", k), int'(sv[k]), 0);
      chk($sformatf("rst_start%0d", k), int'(ss[k]), 0);
      chk($sformatf("rst_i%0d", k), int'(si[k]), 0);
      chk($sformatf("rst_q%0d", k), int'(sq[k]), 0);
      chk($sformatf("rst_ready%0d", k), int'(br[k]), 0);
    end
    rst = 1'b0;
    tick();
    chk("ready_first_cycle", int'(br[0]), 1);

    // Bits 0,0,1,0: first sample two cycles after the fourth bit.
    send_nibble(4'b0010);
    chk("latency_t1_valid", int'(sv[0]), 0);
    tick();
    chk("latency_t2_valid", int'(sv[0]), 1);
    chk("sym0010_i", int'(si[0]), -1943);
    chk("sym0010_q", int'(sq[0]), 1943);
    chk("sym0010_start", int'(ss[0]), 1);
    chk("sym0010_nat_q", int'(sq[1]), 648);
    wait_drain();

    // Partial bits then reset: earlier bits must leave no residue.
    send_bit(1'b1);
    send_bit(1'b1);
    pulse_rst();
    send_nibble(4'b1001);
    tick();
    chk("sym1001_valid", int'(sv[0]), 1);
    chk("sym1001_i", int'(si[0]), 1943);
    chk("sym1001_q", int'(sq[0]), -648);
    wait_drain();

    // Reset in the middle of an emission discards the rest of it.
    send_nibble(4'b0110);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("midemit_rst_valid", int'(sv[0]), 0);
    rst = 1'b0;
    tick();

    // Stall 20 cycles mid-symbol while bits keep coming.
    send_nibble(4'b1100);
    n = 0;
    while (!(sv[0] && !ss[0]) && n < 50) begin
      tick();
      n++;
    end
    chk("stall_reach_phase1", int'(sv[0] && !ss[0]), 1);
    sample_ready = 1'b0;
    pat = 4'b1011;
    acc0 = 0;
    for (int c = 0; c < 20; c++) begin
      bit_valid = 1'b1;
      bit_in    = pat[3 - (c % 4)];
      if (br[0]) acc0++;
      tick();
    end
    chk("stall_bits_accepted", acc0, 4);
    chk("stall_ready_low", int'(br[0]), 0);
    wait_drain();

    // Full symbol sweep; natural 1011 -> (+648,+1943).
    pulse_rst();
    send_nibble(4'b1011);
    n = 0;
    while (!sv[1] && n < 20) begin
      tick();
      n++;
    end
    chk("nat1011_i", int'(si[1]), 648);
    chk("nat1011_q", int'(sq[1]), 1943);
    chk("gray1011_i", int'(si[0]), 1943);
    chk("gray1011_q", int'(sq[0]), 648);
    wait_drain();
    for (int s = 0; s < 16; s++) send_nibble(4'(s));
    wait_drain();

    // Random traffic on both SPS configurations.
    pulse_rst();
    acc0 = 0; acc2 = 0; cyc = 0;
    while ((acc0 < 2000 || acc2 < 2000) && cyc < 40000) begin
      bit_valid    = 1'($urandom_range(0, 1));
      bit_in       = 1'($urandom_range(0, 1));
      sample_ready = 1'($urandom_range(0, 1));
      if (bit_valid && br[0]) acc0++;
      if (bit_valid && br[2]) acc2++;
      tick();
      cyc++;
    end
    chk("random_bits_sps4", int'(acc0 >= 2000), 1);
    chk("random_bits_sps7", int'(acc2 >= 2000), 1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
